// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types for the fetch / load-store memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  // Access size encoding as presented on ls_size (2'b11 is illegal)
  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_e;

  // Requesting port identity, also used as the round-robin pointer
  typedef enum logic {
    P_IF = 1'b0,
    P_LS = 1'b1
  } port_e;

  // Round-robin helper: the port that did not just win
  function automatic port_e other_port(input port_e p);
    return (p == P_IF) ? P_LS : P_IF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Byte/half/word lane handling: load extraction with sign or
//               zero extension, store-word merge, and alignment checking.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed lanes out of the memory word
  always_comb begin
    byte_sel = word_i[8*addr_i +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
  end

  // Load result: extend the selected lane, full word passes through
  always_comb begin
    load_o = word_i;
    case (size_i)
      SZ_B:    load_o = {{24{~uns_i & byte_sel[7]}}, byte_sel};
      SZ_H:    load_o = {{16{~uns_i & half_sel[15]}}, half_sel};
      default: load_o = word_i;
    endcase
  end

  // Store word: replace only the addressed lane of the old word
  always_comb begin
    store_o = word_i;
    case (size_i)
      SZ_B: store_o[8*addr_i +: 8] = wdata_i[7:0];
      SZ_H: begin
        if (addr_i[1]) store_o[31:16] = wdata_i[15:0];
        else           store_o[15:0]  = wdata_i[15:0];
      end
      default: store_o = wdata_i;
    endcase
  end

  // Illegal size, odd half address, or unaligned word
  always_comb begin
    misalign_o = (size_i == 2'b11) ||
                 ((size_i == SZ_H) && addr_i[0]) ||
                 ((size_i == SZ_W) && (addr_i != 2'b00));
  end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one word-wide memory between the instruction-fetch
//               port and the load/store port. Round-robin arbitration,
//               read-modify-write for sub-word stores, load extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDW  = 12,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_err,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [1:0]       ls_size,
  input  logic             ls_unsigned,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  output logic             ls_rvalid,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             ls_err,
  output logic [ADDW-1:0]  mem_address,
  output logic [WIDTH-1:0] mem_data_in,
  output logic             mem_str,
  output logic [1:0]       mem_byte_masking,
  input  logic [WIDTH-1:0] mem_data_out
);

  // Byte-address bits that reach the memory; anything above aliases
  localparam int AW = ADDW + 2;

  state_e           state_q, state_d;
  port_e            rr_q;
  port_e            port_q;
  logic [AW-1:0]    addr_q;
  logic [1:0]       size_q;
  logic             we_q;
  logic             uns_q;
  logic             err_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] word_q;

  logic             any_req;
  port_e            win_port;
  logic             win_is_if;
  logic [AW-1:0]    win_addr;
  logic [1:0]       win_size;
  logic             win_we;
  logic [1:0]       al_addr;
  logic [1:0]       al_size;
  logic [WIDTH-1:0] al_load;
  logic [WIDTH-1:0] al_store;
  logic             al_misalign;
  logic             unused_addr_hi;

  assign unused_addr_hi = ^{if_addr[WIDTH-1:AW], ls_addr[WIDTH-1:AW]};

  // Choose the winning requester and its access attributes
  always_comb begin
    any_req  = if_req | ls_req;
    win_port = P_LS;
    if (if_req && ls_req) win_port = rr_q;
    else if (if_req)      win_port = P_IF;
    win_is_if = (win_port == P_IF);
    win_addr  = win_is_if ? if_addr[AW-1:0] : ls_addr[AW-1:0];
    win_size  = win_is_if ? SZ_W : ls_size;
    win_we    = !win_is_if && ls_we;
    // The aligner checks the incoming request in IDLE, the latched one after
    al_addr   = (state_q == IDLE) ? win_addr[1:0] : addr_q[1:0];
    al_size   = (state_q == IDLE) ? win_size      : size_q;
  end

  mem_lane_align u_align (
    .word_i     (word_q),
    .addr_i     (al_addr),
    .size_i     (al_size),
    .uns_i      (uns_q),
    .wdata_i    (wdata_q),
    .load_o     (al_load),
    .store_o    (al_store),
    .misalign_o (al_misalign)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state sequencing and per-state output drive
  always_comb begin
    state_d     = state_q;
    if_rvalid   = 1'b0;
    if_rdata    = '0;
    if_err      = 1'b0;
    ls_rvalid   = 1'b0;
    ls_rdata    = '0;
    ls_err      = 1'b0;
    mem_str     = 1'b0;
    mem_data_in = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          if (al_misalign)                     state_d = RESP;
          else if (win_we && win_size == SZ_W) state_d = WR;
          else                                 state_d = RD;
        end
      end
      RD: state_d = we_q ? WR : RESP;
      WR: begin
        mem_str     = 1'b1;
        mem_data_in = al_store;
        state_d     = RESP;
      end
      RESP: begin
        state_d = IDLE;
        if (port_q == P_IF) begin
          if_rvalid = 1'b1;
          if_err    = err_q;
          if_rdata  = err_q ? '0 : word_q;
        end else begin
          ls_rvalid = 1'b1;
          ls_err    = err_q;
          ls_rdata  = (err_q || we_q) ? '0 : al_load;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_address      = addr_q[AW-1:2];
  assign mem_byte_masking = addr_q[1:0];

  // Latch the granted request in IDLE and capture read data at the end of RD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= P_LS;
      port_q  <= P_LS;
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      if (state_q == IDLE && any_req) begin
        port_q  <= win_port;
        rr_q    <= other_port(win_port);
        addr_q  <= win_addr;
        size_q  <= win_size;
        we_q    <= win_we;
        uns_q   <= !win_is_if && ls_unsigned;
        wdata_q <= win_is_if ? '0 : ls_wdata;
        err_q   <= al_misalign;
      end
      if (state_q == RD) word_q <= mem_data_out;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter with a behavioural
//               memory and a word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [1:0]  ls_size = 2'b00;
  logic        ls_unsigned = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        ls_err;
  logic [11:0] mem_address;
  logic [31:0] mem_data_in;
  logic        mem_str;
  logic [1:0]  mem_byte_masking;
  logic [31:0] mem_data_out;

  logic [31:0] mem     [0:4095];
  logic [31:0] ref_mem [0:4095];
  logic        pre_we = 1'b0;
  logic [11:0] pre_idx = '0;
  logic [31:0] pre_val = '0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_rdata;
  logic [31:0] saved;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDW(12), .WIDTH(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_req           (if_req),
    .if_addr          (if_addr),
    .if_rvalid        (if_rvalid),
    .if_rdata         (if_rdata),
    .if_err           (if_err),
    .ls_req           (ls_req),
    .ls_we            (ls_we),
    .ls_size          (ls_size),
    .ls_unsigned      (ls_unsigned),
    .ls_addr          (ls_addr),
    .ls_wdata         (ls_wdata),
    .ls_rvalid        (ls_rvalid),
    .ls_rdata         (ls_rdata),
    .ls_err           (ls_err),
    .mem_address      (mem_address),
    .mem_data_in      (mem_data_in),
    .mem_str          (mem_str),
    .mem_byte_masking (mem_byte_masking),
    .mem_data_out     (mem_data_out)
  );

  // Memory: combinational read, synchronous full-word write
  assign mem_data_out = mem[mem_address];
  always @(posedge clk) begin
    if (pre_we)  mem[pre_idx]     <= pre_val;
    if (mem_str) mem[mem_address] <= mem_data_in;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input int i, input logic [31:0] v);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = 12'(i); pre_val = v;
    ref_mem[i] = v;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // One access on one port, checked against the reference word array
  task automatic txn(input bit is_if, input bit we, input bit [1:0] sz, input bit uns,
                     input bit [31:0] addr, input bit [31:0] wd);
    logic [11:0] idx;
    logic [31:0] e_rd, e_ww;
    longint unsigned w64, wd64, m, v, r;
    bit e_err, got;
    int e_lat, e_nw, nw, lat, sh, nb;
    idx  = addr[13:2];
    w64  = {32'd0, ref_mem[idx]};
    wd64 = {32'd0, wd};
    sh   = 8 * int'(addr[1:0]);
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m    = (64'd1 << (8 * nb)) - 64'd1;
    e_rd = '0; e_ww = ref_mem[idx]; e_nw = 0;
    if (is_if) begin
      e_err = (addr[1:0] != 2'd0);
      e_rd  = ref_mem[idx];
      e_lat = e_err ? 1 : 2;
    end else begin
      e_err = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'd0);
      if (e_err) e_lat = 1;
      else if (!we) begin
        v = (w64 >> sh) & m;
        if (!uns && v[8*nb-1]) v = v | ~m;
        e_rd  = v[31:0];
        e_lat = 2;
      end else begin
        r = (w64 & ~(m << sh)) | ((wd64 & m) << sh);
        e_ww = r[31:0];
        e_nw = 1;
        e_lat = (sz == 2'd2) ? 2 : 3;
        ref_mem[idx] = e_ww;
      end
    end
    @(negedge clk);
    if (is_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      ls_req = 1'b1; ls_we = we; ls_size = sz; ls_unsigned = uns; ls_addr = addr; ls_wdata = wd;
    end
    @(posedge clk); #1;
    lat = 1; got = 1'b0; nw = 0;
    while (!got && lat <= 6) begin
      if (mem_str) begin
        nw++;
        check_eq("wr_addr", 32'(mem_address), 32'(idx));
        check_eq("wr_data", mem_data_in, e_ww);
        check_eq("wr_mask", 32'(mem_byte_masking), 32'(addr[1:0]));
      end
      if (is_if ? if_rvalid : ls_rvalid) got = 1'b1;
      else begin
        @(posedge clk); #1; lat++;
      end
    end
    check_eq("resp_seen", 32'(got), 32'd1);
    if (got) begin
      check_eq("latency", 32'(lat), 32'(e_lat));
      check_eq("err", 32'(is_if ? if_err : ls_err), 32'(e_err));
      last_rdata = is_if ? if_rdata : ls_rdata;
      if (!e_err) check_eq("rdata", last_rdata, e_rd);
      check_eq("other_rvalid", 32'(is_if ? ls_rvalid : if_rvalid), 32'd0);
    end
    check_eq("write_count", 32'(nw), 32'(e_nw));
    if (is_if) if_req = 1'b0; else ls_req = 1'b0;
    @(posedge clk); #1;
    check_eq("rvalid_pulse", 32'(is_if ? if_rvalid : ls_rvalid), 32'd0);
    check_eq("str_after", 32'(mem_str), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fill memory while the DUT is held in reset
    for (int i = 0; i < 64; i++) preload(i, $urandom());
    @(posedge clk); #1;
    check_eq("rst_ctrl", {27'd0, if_rvalid, if_err, ls_rvalid, ls_err, mem_str}, 32'd0);
    check_eq("rst_if_rdata", if_rdata, 32'd0);
    check_eq("rst_ls_rdata", ls_rdata, 32'd0);
    check_eq("rst_mem_addr", 32'(mem_address), 32'd0);
    check_eq("rst_mem_din", mem_data_in, 32'd0);
    check_eq("rst_mask", 32'(mem_byte_masking), 32'd0);

    // Both ports requesting out of reset: LS first, then alternation
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 32'h44;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      int cnt;
      cnt = 0;
      while (!(if_rvalid || ls_rvalid) && cnt < 8) begin
        @(posedge clk); #1; cnt++;
      end
      check_eq("arb_resp_seen", 32'(if_rvalid || ls_rvalid), 32'd1);
      check_eq("arb_order_ls", 32'(ls_rvalid), 32'(k % 2 == 0));
      check_eq("arb_order_if", 32'(if_rvalid), 32'(k % 2 == 1));
      if (ls_rvalid) begin check_eq("arb_ls_data", ls_rdata, ref_mem[17]); ls_req = 1'b0; end
      if (if_rvalid) begin check_eq("arb_if_data", if_rdata, ref_mem[16]); if_req = 1'b0; end
      @(posedge clk); #1;
      if (k < 3) begin if_req = 1'b1; ls_req = 1'b1; end
      else       begin if_req = 1'b0; ls_req = 1'b0; end
    end
    repeat (2) @(posedge clk);

    // Directed accesses
    preload(5, 32'h8899AABB);
    txn(0, 0, 2'd0, 0, 32'h15, 32'h0);
    check_eq("ld_byte_signed", last_rdata, 32'hFFFFFFAA);
    txn(0, 1, 2'd1, 0, 32'h16, 32'h1234);
    txn(0, 0, 2'd2, 0, 32'h14, 32'h0);
    check_eq("ld_after_rmw", last_rdata, 32'h1234AABB);
    preload(8, 32'h01020304);
    txn(0, 1, 2'd2, 0, 32'h22, 32'hDEADBEEF);
    check_eq("mem8_kept", mem[8], 32'h01020304);
    preload(5, 32'h80000000);
    txn(0, 0, 2'd1, 1, 32'h16, 32'h0);
    check_eq("ld_half_uns", last_rdata, 32'h00008000);
    txn(0, 0, 2'd1, 0, 32'h16, 32'h0);
    check_eq("ld_half_sgn", last_rdata, 32'hFFFF8000);
    txn(0, 0, 2'd3, 0, 32'h10, 32'h0);
    txn(1, 0, 2'd2, 0, 32'h14, 32'h0);
    txn(1, 0, 2'd2, 0, 32'h17, 32'h0);
    txn(0, 1, 2'd0, 0, 32'hFFFF_C00B, 32'h77);

    // Randomized single-port traffic over a small aliased window
    for (int n = 0; n < 80; n++) begin
      bit          r_if, r_we, r_uns;
      bit [1:0]    r_sz;
      bit [31:0]   r_addr;
      r_if   = ($urandom_range(0, 3) == 0);
      r_we   = 1'($urandom_range(0, 1));
      r_uns  = 1'($urandom_range(0, 1));
      r_sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      r_addr = ($urandom_range(0, 1) == 1) ? ($urandom() & 32'hFFFF_C000) : 32'd0;
      r_addr = r_addr | (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      txn(r_if, r_we, r_sz, r_uns, r_addr, $urandom());
    end

    // Reset during the read phase of a byte store
    preload(12, 32'hCAFEF00D);
    @(negedge clk);
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'd0; ls_unsigned = 1'b0; ls_addr = 32'h31; ls_wdata = 32'h5A;
    @(posedge clk); #1;
    check_eq("rst_rd_nostr", 32'(mem_str), 32'd0);
    #2; rst_n = 1'b0; #1;
    check_eq("rst_mid_ctrl", {27'd0, if_rvalid, if_err, ls_rvalid, ls_err, mem_str}, 32'd0);
    check_eq("rst_mid_rdata", if_rdata | ls_rdata, 32'd0);
    check_eq("rst_mid_mem", {mem_data_in}, 32'd0);
    check_eq("rst_mid_addr", {18'd0, mem_address, mem_byte_masking}, 32'd0);
    ls_req = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("rst_hold_str", 32'(mem_str), 32'd0);
    end
    check_eq("rst_mem_kept", mem[12], 32'hCAFEF00D);
    @(negedge clk); rst_n = 1'b1;
    txn(0, 1, 2'd0, 0, 32'h31, 32'h5A);
    txn(0, 0, 2'd2, 0, 32'h30, 32'h0);
    check_eq("reissue_word", last_rdata, 32'hCAFE5A0D);

    // Final memory image against the reference
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) check_eq("mem_final", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // At most one response pulse in any cycle
  always @(negedge clk) begin
    if (rst_n && (if_rvalid || ls_rvalid))
      check_eq("single_rvalid", 32'(if_rvalid && ls_rvalid), 32'd0);
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port word memory (12-bit word address, combinational read, synchronous write) between two requesters: the instruction-fetch port (read-only) and the load/store port (byte/half/word, signed/unsigned).
- The memory always writes a full word on a store, so sub-word stores are done here as a read-modify-write sequence.
- Performs load lane extraction, sign/zero extension and alignment checking.
- Sits between the core front-end/LSU and the memory instance.

Parameters:
- ADDW, 12, memory word-address width. The word index is taken from byte address bits [ADDW+1:2]; higher bits are ignored, so addresses alias.
- WIDTH, 32, data width. Fixed at 32; other values are unsupported.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held high until if_rvalid
- if_addr  in  32  fetch byte address
- if_rvalid  out  1  one-cycle response pulse
- if_rdata  out  32  fetched word
- if_err  out  1  misaligned fetch, valid with if_rvalid
- ls_req  in  1  load/store request, held high until ls_rvalid
- ls_we  in  1  1 = store, 0 = load
- ls_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- ls_unsigned  in  1  zero-extend loads when 1
- ls_addr  in  32  byte address
- ls_wdata  in  32  store data, right-aligned
- ls_rvalid  out  1  one-cycle response pulse, for loads and stores
- ls_rdata  out  32  extended load data; 0 for stores
- ls_err  out  1  misaligned access or illegal size, valid with ls_rvalid
- mem_address  out  ADDW  word address to memory
- mem_data_in  out  32  full merged write word
- mem_str  out  1  memory write enable
- mem_byte_masking  out  2  lane select; driven with addr[1:0] of the current access
- mem_data_out  in  32  combinational read data from memory

Behaviour:
- Reset (asynchronous, active low):
  - State goes to IDLE.
  - All outputs go to 0: rvalid, err, rdata, mem_str, mem_address, mem_data_in, mem_byte_masking.
  - The round-robin pointer goes to LS.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - Samples if_req and ls_req at the clock edge.
  - If both are high, the port selected by the round-robin pointer wins. After each grant, the pointer moves to the other port.
  - If only one is high, that port wins.
  - The winning request's addr, size, we, wdata and unsigned are latched.
- Alignment check, done in IDLE:
  - Half access with addr[0] = 1 is an error.
  - Word access or fetch with addr[1:0] != 0 is an error.
  - ls_size = 11 is an error.
  - On error: go to RESP with err = 1. No memory access occurs and mem_str stays 0.
- Path after a legal grant:
  - Load or fetch: go to RD.
  - Word store: go to WR.
  - Byte or half store: go to RD, then WR (read-modify-write).
- RD (one cycle):
  - mem_address = latched addr[ADDW+1:2]; mem_data_out is registered at the cycle's end.
  - Load/fetch then goes to RESP; sub-word store goes to WR.
- WR (one cycle):
  - mem_str = 1; mem_data_in is the registered read word with the selected byte or half lane replaced by wdata[7:0] or wdata[15:0].
  - A word store writes wdata unchanged. Then go to RESP.
- RESP (one cycle):
  - The owning port's rvalid = 1 with rdata/err; then go to IDLE.
  - Only one rvalid is ever high.
- Latency from the req sampling edge to the rvalid cycle: load/fetch 2 cycles, word store 2, sub-word store 3, error 1.
- Load extraction:
  - Byte: lane addr[1:0].
  - Half: bits [15:0] when addr[1] = 0, bits [31:16] when addr[1] = 1.
  - Result is sign-extended unless ls_unsigned is 1. Fetch returns the raw word.
- Requester handshake: the requester drops req on the edge where it samples rvalid high. A req that is high in IDLE is treated as a new request.
- Requests are ignored outside IDLE. A held req from the losing port is serviced at the next IDLE.
- Reset mid-operation: an RMW aborted before WR produces no write. mem_str deasserts asynchronously, and the request is lost; the requester must reissue it.

Decomposition:
- Package mem_arb_pkg holds:
  - size_e enum (SZ_B, SZ_H, SZ_W).
  - state_e enum (IDLE, RD, WR, RESP).
  - port_e enum (P_IF, P_LS).
- Sub-module mem_lane_align (combinational):
  - Inputs: word, addr[1:0], size, unsigned, wdata.
  - Outputs: extended load data, merged store word, misalign flag.

Test Plan:
- Preload mem[5] = 0x8899AABB; load byte, signed, addr 0x15 -> ls_rvalid 2 cycles after sampling, ls_rdata 0xFFFFFFAA, ls_err 0.
- Store half 0x1234 to addr 0x16 over mem[5] = 0x8899AABB -> one RD cycle, then WR with mem_data_in 0x1234AABB and mem_str high for exactly 1 cycle; later load of word 0x14 returns 0x1234AABB.
- if_req and ls_req both high from reset -> LS served first, then IF; with both held, grants alternate IF, LS, IF across three accesses.
- Store word to addr 0x22 -> ls_rvalid with ls_err 1 one cycle after sampling; mem_str never asserts; mem[8] unchanged.
- Load half, unsigned, addr 0x16 with mem[5] = 0x8000_0000 -> ls_rdata 0x00008000; same access signed -> 0xFFFF8000.
- Assert rst_n low during the RD cycle of a byte store -> mem_str stays 0, memory unchanged, all outputs 0; a reissued request after reset completes normally.
